// File: rtl/bp_resolve_update.sv
// rtl/bp_resolve_update.sv - branch resolve compare, redirect, BHT train and BTB update queue
module bp_resolve_update #(
    parameter int VLEN           = 64,
    parameter int BHT_NR_ENTRIES = 128,
    parameter int BTB_NR_ENTRIES = 8,
    parameter int UPD_FIFO_DEPTH = 2,
    localparam int BHT_IDX_W     = $clog2(BHT_NR_ENTRIES),
    localparam int BTB_IDX_W     = $clog2(BTB_NR_ENTRIES)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 res_valid_i,
    input  logic [VLEN-1:0]      res_pc_i,
    input  logic [1:0]           res_kind_i,
    input  logic                 res_taken_i,
    input  logic [VLEN-1:0]      res_target_i,
    input  logic                 pred_taken_i,
    input  logic [VLEN-1:0]      pred_target_i,
    input  logic                 flush_done_i,
    output logic                 mispredict_o,
    output logic [VLEN-1:0]      redirect_pc_o,
    output logic                 bht_upd_valid_o,
    output logic [BHT_IDX_W-1:0] bht_upd_idx_o,
    output logic                 bht_upd_taken_o,
    output logic                 btb_upd_valid_o,
    input  logic                 btb_upd_ready_i,
    output logic [BTB_IDX_W-1:0] btb_upd_idx_o,
    output logic [VLEN-1:0]      btb_upd_target_o,
    output logic [31:0]          perf_branches_o,
    output logic [31:0]          perf_mispred_o
);
    localparam int PTR_W = $clog2(UPD_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {RUN, FLUSH} state_e;
    state_e state_q, state_d;

    logic accept, tgt_miss, miss, bht_train, btb_push_req;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= RUN;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (miss) state_d = FLUSH;
            FLUSH:   if (flush_done_i) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        accept       = res_valid_i && (state_q == RUN);
        tgt_miss     = res_taken_i && pred_taken_i && (res_target_i != pred_target_i);
        miss         = accept && ((res_taken_i != pred_taken_i) || tgt_miss);
        bht_train    = accept && (res_kind_i == 2'd0);
        // returns are predicted by the RAS, so they never train the BTB
        btb_push_req = accept && res_taken_i && (res_kind_i != 2'd3) && (tgt_miss || !pred_taken_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mispredict_o    <= 1'b0;
            redirect_pc_o   <= '0;
            bht_upd_valid_o <= 1'b0;
            bht_upd_idx_o   <= '0;
            bht_upd_taken_o <= 1'b0;
            perf_branches_o <= '0;
            perf_mispred_o  <= '0;
        end else begin
            mispredict_o    <= miss;
            bht_upd_valid_o <= bht_train;
            if (miss)
                redirect_pc_o <= res_taken_i ? res_target_i : res_pc_i + VLEN'(4);
            if (bht_train) begin
                bht_upd_idx_o   <= res_pc_i[BHT_IDX_W:1];
                bht_upd_taken_o <= res_taken_i;
            end
            if (accept && perf_branches_o != 32'hFFFF_FFFF)
                perf_branches_o <= perf_branches_o + 32'd1;
            if (miss && perf_mispred_o != 32'hFFFF_FFFF)
                perf_mispred_o <= perf_mispred_o + 32'd1;
        end
    end

    logic [BTB_IDX_W-1:0] fifo_idx_q [UPD_FIFO_DEPTH];
    logic [VLEN-1:0]      fifo_tgt_q [UPD_FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 pop, push;

    // a pop in the same cycle frees the slot, so a full queue still takes the push
    always_comb begin
        pop  = btb_upd_valid_o && btb_upd_ready_i;
        push = btb_push_req && ((count_q != CNT_W'(UPD_FIFO_DEPTH)) || pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_idx_q[wr_ptr_q] <= res_pc_i[BTB_IDX_W:1];
            fifo_tgt_q[wr_ptr_q] <= res_target_i;
        end
    end

    always_comb begin
        btb_upd_valid_o  = (count_q != '0);
        btb_upd_idx_o    = btb_upd_valid_o ? fifo_idx_q[rd_ptr_q] : '0;
        btb_upd_target_o = btb_upd_valid_o ? fifo_tgt_q[rd_ptr_q] : '0;
    end
endmodule
